// File: rtl/sdram_sched_pkg.sv
// rtl/sdram_sched_pkg.sv - shared state encoding and address field offsets for the SDRAM request scheduler
package sdram_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACK,
        S_DONE,
        S_ABORT
    } sched_state_t;

    localparam int COL_LSB  = 0;
    localparam int ROW_LSB  = 9;
    localparam int BANK_LSB = 22;

endpackage

// File: rtl/sdram_req_sched_if.sv
// rtl/sdram_req_sched_if.sv - host-side command/completion bundle of the SDRAM request scheduler
interface sdram_req_sched_if #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 9
) ();

    logic              host_req_valid;
    logic              host_req_ready;
    logic              host_req_rw_n;
    logic [ADDR_W-1:0] host_req_addr;
    logic [LEN_W-1:0]  host_req_len;
    logic              host_done;
    logic              host_done_rw_n;
    logic              host_err;

    modport master (
        output host_req_valid, host_req_rw_n, host_req_addr, host_req_len,
        input  host_req_ready, host_done, host_done_rw_n, host_err
    );

    modport slave (
        input  host_req_valid, host_req_rw_n, host_req_addr, host_req_len,
        output host_req_ready, host_done, host_done_rw_n, host_err
    );

endinterface

// File: rtl/sdram_cmd_fifo.sv
// rtl/sdram_cmd_fifo.sv - in-order synchronous command FIFO with same-cycle push/pop
module sdram_cmd_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                     clk_100m,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk_100m) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sdram_req_sched.sv
// rtl/sdram_req_sched.sv - queues host commands and issues them one at a time to the SDRAM controller
module sdram_req_sched
    import sdram_sched_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 9,
    parameter int DEPTH  = 4,
    parameter int TMO    = 4095
) (
    input  logic              clk_100m,
    input  logic              rst,
    sdram_req_sched_if.slave  host,
    input  logic              sdram_init_done,
    input  logic              sdram_wr_ack,
    input  logic              sdram_rd_ack,
    output logic              sdram_wr_req,
    output logic              sdram_rd_req,
    output logic [LEN_W-1:0]  sdwr_bytes,
    output logic [LEN_W-1:0]  sdrd_bytes,
    output logic [ADDR_W-1:0] sys_addr
);

    localparam int CMD_W = 1 + ADDR_W + LEN_W;
    localparam int TW    = $clog2(TMO + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TMO);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    sched_state_t      state, state_nx;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PW:0]       fifo_count;
    logic [CMD_W-1:0]  head;
    logic              pop;
    logic              act_rw_n;
    logic [ADDR_W-1:0] act_addr;
    logic [LEN_W-1:0]  act_len;
    logic [TW-1:0]     tmo_cnt;
    logic              ack;

    assign host.host_req_ready = (fifo_count != FULL_CNT);

    sdram_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_100m (clk_100m),
        .rst      (rst),
        .push     (host.host_req_valid && !fifo_full),
        .wdata    ({host.host_req_rw_n, host.host_req_addr, host.host_req_len}),
        .pop      (pop),
        .rdata    (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Only the ack matching the active direction can move the FSM.
    assign ack = act_rw_n ? sdram_wr_ack : sdram_rd_ack;

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty && sdram_init_done) begin
                    pop      = 1'b1;
                    state_nx = (head[LEN_W-1:0] == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (ack)                    state_nx = S_ACK;
                else if (tmo_cnt == TMO_MAX) state_nx = S_ABORT;
            end
            S_ACK:   if (!ack) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            S_ABORT: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            state    <= S_IDLE;
            act_rw_n <= 1'b0;
            act_addr <= '0;
            act_len  <= '0;
            tmo_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (pop) begin
                act_rw_n <= head[CMD_W-1];
                act_addr <= head[LEN_W +: ADDR_W];
                act_len  <= head[LEN_W-1:0];
            end
            // Held at zero outside REQ so every entry starts a fresh count.
            if (state != S_REQ)
                tmo_cnt <= '0;
            else if (tmo_cnt != TMO_MAX)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign sdram_wr_req        = (state == S_REQ) && act_rw_n;
    assign sdram_rd_req        = (state == S_REQ) && !act_rw_n;
    assign sdwr_bytes          = act_rw_n ? act_len : '0;
    assign sdrd_bytes          = act_rw_n ? '0 : act_len;
    assign sys_addr            = act_addr;
    assign host.host_done      = (state == S_DONE);
    assign host.host_done_rw_n = (state == S_DONE) && act_rw_n;
    assign host.host_err       = (state == S_ABORT);

endmodule

// File: tb/tb_sdram_req_sched.sv
// tb/tb_sdram_req_sched.sv - directed self-checking bench for sdram_req_sched
module tb_sdram_req_sched;

    localparam int ADDR_W = 24;
    localparam int LEN_W  = 9;
    localparam int DEPTH  = 4;
    localparam int TMO    = 15;

    logic              clk_100m = 1'b0;
    logic              rst = 1'b1;
    logic              sdram_init_done = 1'b0;
    logic              sdram_wr_ack = 1'b0;
    logic              sdram_rd_ack = 1'b0;
    logic              sdram_wr_req;
    logic              sdram_rd_req;
    logic [LEN_W-1:0]  sdwr_bytes;
    logic [LEN_W-1:0]  sdrd_bytes;
    logic [ADDR_W-1:0] sys_addr;

    int n_cmp    = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int exp_done = 0;
    int exp_err  = 0;

    sdram_req_sched_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) hif ();

    sdram_req_sched #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .DEPTH  (DEPTH),
        .TMO    (TMO)
    ) dut (
        .clk_100m        (clk_100m),
        .rst             (rst),
        .host            (hif),
        .sdram_init_done (sdram_init_done),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_rd_ack    (sdram_rd_ack),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_rd_req    (sdram_rd_req),
        .sdwr_bytes      (sdwr_bytes),
        .sdrd_bytes      (sdrd_bytes),
        .sys_addr        (sys_addr)
    );

    always #5 clk_100m = ~clk_100m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_100m) begin
        if (!rst) begin
            if (hif.host_done) done_cnt++;
            if (hif.host_err)  err_cnt++;
            check("req_exclusive", {31'b0, sdram_wr_req & sdram_rd_req}, 32'd0);
        end
    end

    task automatic tick();
        @(negedge clk_100m);
    endtask

    task automatic push(input logic rw, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
        check("push_ready", hif.host_req_ready, 1);
        hif.host_req_valid = 1'b1;
        hif.host_req_rw_n  = rw;
        hif.host_req_addr  = addr;
        hif.host_req_len   = len;
        tick();
        hif.host_req_valid = 1'b0;
    endtask

    task automatic serve(input logic rw, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                         input int ack_cyc);
        int i = 0;
        while (!(sdram_wr_req || sdram_rd_req) && i < 60) begin
            tick();
            i++;
        end
        check("serve_req_seen", sdram_wr_req | sdram_rd_req, 1);
        check("serve_dir", sdram_wr_req, rw);
        check("serve_addr", sys_addr, addr);
        check("serve_bytes", rw ? sdwr_bytes : sdrd_bytes, len);
        check("serve_other_bytes", rw ? sdrd_bytes : sdwr_bytes, 0);
        if (rw) sdram_wr_ack = 1'b1;
        else    sdram_rd_ack = 1'b1;
        tick();
        check("serve_req_drop", sdram_wr_req | sdram_rd_req, 0);
        repeat (ack_cyc - 1) tick();
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        tick();
        check("serve_done", hif.host_done, 1);
        check("serve_done_rw", hif.host_done_rw_n, rw);
        tick();
        check("serve_done_pulse", hif.host_done, 0);
    endtask

    initial begin
        logic seen;
        int   n;
        hif.host_req_valid = 1'b0;
        hif.host_req_rw_n  = 1'b0;
        hif.host_req_addr  = '0;
        hif.host_req_len   = '0;

        // Reset values
        repeat (3) tick();
        check("rst_ready", hif.host_req_ready, 1);
        check("rst_wr_req", sdram_wr_req, 0);
        check("rst_rd_req", sdram_rd_req, 0);
        check("rst_done", hif.host_done, 0);
        check("rst_done_rw", hif.host_done_rw_n, 0);
        check("rst_err", hif.host_err, 0);
        check("rst_addr", sys_addr, 0);
        check("rst_wr_bytes", sdwr_bytes, 0);
        check("rst_rd_bytes", sdrd_bytes, 0);
        rst = 1'b0;
        tick();

        // Single write with pop latency
        sdram_init_done = 1'b1;
        push(1'b1, 24'h012345, 9'd8);
        check("lat_wr_early", sdram_wr_req, 0);
        tick();
        check("lat_wr_req", sdram_wr_req, 1);
        serve(1'b1, 24'h012345, 9'd8, 3);
        exp_done++;
        #2 check("single_done_cnt", done_cnt, exp_done);

        // Back-to-back fill, fifth command refused while full
        sdram_init_done = 1'b0;
        tick();
        push(1'b1, 24'h100000, 9'd4);
        push(1'b0, 24'h200400, 9'd16);
        push(1'b1, 24'h3FFE00, 9'd1);
        push(1'b0, 24'h000001, 9'd511);
        check("fill_ready_low", hif.host_req_ready, 0);
        hif.host_req_valid = 1'b1;
        hif.host_req_rw_n  = 1'b1;
        hif.host_req_addr  = 24'h0ABCDE;
        hif.host_req_len   = 9'd5;
        tick();
        check("fill_ready_still_low", hif.host_req_ready, 0);
        hif.host_req_valid = 1'b0;
        sdram_init_done = 1'b1;
        serve(1'b1, 24'h100000, 9'd4, 1);
        serve(1'b0, 24'h200400, 9'd16, 2);
        serve(1'b1, 24'h3FFE00, 9'd1, 3);
        serve(1'b0, 24'h000001, 9'd511, 4);
        exp_done += 4;
        repeat (4) tick();
        check("fill_no_fifth", sdram_wr_req | sdram_rd_req, 0);
        #2 check("fill_done_cnt", done_cnt, exp_done);

        // Init gating
        sdram_init_done = 1'b0;
        tick();
        push(1'b0, 24'h3FFFFF, 9'd2);
        seen = 1'b0;
        repeat (100) begin
            if (sdram_wr_req || sdram_rd_req) seen = 1'b1;
            tick();
        end
        check("gate_no_req", seen, 0);
        sdram_init_done = 1'b1;
        tick();
        check("gate_rd_req", sdram_rd_req, 1);
        serve(1'b0, 24'h3FFFFF, 9'd2, 2);
        exp_done++;

        // Ack while idle is ignored
        sdram_rd_ack = 1'b1;
        tick();
        tick();
        check("idle_ack_no_done", hif.host_done, 0);
        check("idle_ack_no_req", sdram_wr_req | sdram_rd_req, 0);
        sdram_rd_ack = 1'b0;
        tick();

        // Wrong-direction ack keeps a read request up
        push(1'b0, 24'h001234, 9'd3);
        tick();
        check("wrong_rd_req", sdram_rd_req, 1);
        sdram_wr_ack = 1'b1;
        tick();
        check("wrong_ack_hold1", sdram_rd_req, 1);
        tick();
        check("wrong_ack_hold2", sdram_rd_req, 1);
        check("wrong_ack_no_done", hif.host_done, 0);
        sdram_wr_ack = 1'b0;
        serve(1'b0, 24'h001234, 9'd3, 1);
        exp_done++;

        // Zero-length command
        push(1'b1, 24'h00AA55, 9'd0);
        check("zl_early", hif.host_done, 0);
        tick();
        check("zl_done", hif.host_done, 1);
        check("zl_done_rw", hif.host_done_rw_n, 1);
        check("zl_no_req", sdram_wr_req | sdram_rd_req, 0);
        tick();
        check("zl_pulse", hif.host_done, 0);
        check("zl_no_req_after", sdram_wr_req | sdram_rd_req, 0);
        exp_done++;
        #2 check("mid_done_cnt", done_cnt, exp_done);

        // Timeout: write never acked, queued read follows
        tick();
        push(1'b1, 24'h000100, 9'd32);
        push(1'b0, 24'h000200, 9'd4);
        n = 0;
        while (sdram_wr_req && n < 40) begin
            n++;
            tick();
        end
        check("tmo_req_cycles", n, 16);
        check("tmo_err", hif.host_err, 1);
        check("tmo_no_done", hif.host_done, 0);
        tick();
        check("tmo_err_pulse", hif.host_err, 0);
        serve(1'b0, 24'h000200, 9'd4, 2);
        exp_done++;
        exp_err++;
        #2;
        check("tmo_err_cnt", err_cnt, exp_err);
        check("tmo_done_cnt", done_cnt, exp_done);

        // Reset during ACK with two commands queued
        tick();
        push(1'b1, 24'h0C0C0C, 9'd8);
        push(1'b0, 24'h0D0D0D, 9'd4);
        push(1'b0, 24'h0E0E0E, 9'd4);
        check("rma_wr_req", sdram_wr_req, 1);
        sdram_wr_ack = 1'b1;
        tick();
        check("rma_in_ack", sdram_wr_req, 0);
        rst = 1'b1;
        tick();
        check("rma_ready", hif.host_req_ready, 1);
        check("rma_wr_req_low", sdram_wr_req, 0);
        check("rma_rd_req_low", sdram_rd_req, 0);
        check("rma_done", hif.host_done, 0);
        check("rma_err", hif.host_err, 0);
        check("rma_addr", sys_addr, 0);
        check("rma_wr_bytes", sdwr_bytes, 0);
        rst = 1'b0;
        sdram_wr_ack = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (sdram_wr_req || sdram_rd_req || hif.host_done) seen = 1'b1;
        end
        check("rma_queue_flushed", seen, 0);
        #2 check("rma_done_cnt", done_cnt, exp_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
